// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier family.
package booth_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    typedef enum logic [2:0] {ZERO, ADD1, ADD2, SUB1, SUB2} booth_op_t;

    // Multiplier is widened to an even width with at least one sign-guard bit.
    function automatic int xb_of(input int wb);
        return (wb % 2 == 0) ? wb + 2 : wb + 1;
    endfunction

endpackage

// File: rtl/booth4_mul_param_if.sv
// op_start/op_clear/op_done handshake plus operand and product bus.
interface booth4_mul_param_if #(
    parameter int WA = 64,
    parameter int WB = 64
);
    logic                 op_start;
    logic                 op_clear;
    logic                 signed_mode;
    logic [WA-1:0]        mtplicand;
    logic [WB-1:0]        mtplier;
    logic                 busy;
    logic                 op_done;
    logic [WA+WB-1:0]     result;

    modport master (
        output op_start, op_clear, signed_mode, mtplicand, mtplier,
        input  busy, op_done, result
    );

    modport slave (
        input  op_start, op_clear, signed_mode, mtplicand, mtplier,
        output busy, op_done, result
    );
endinterface

// File: rtl/booth4_recode.sv
// Radix-4 Booth digit recoder: {x[2i+1], x[2i], x[2i-1]} -> operation.
module booth4_recode
    import booth_pkg::*;
(
    input  logic [2:0] i_trip,
    output booth_op_t  o_op
);
    always_comb begin
        o_op = ZERO;
        case (i_trip)
            3'b001, 3'b010: o_op = ADD1;
            3'b011:         o_op = ADD2;
            3'b100:         o_op = SUB2;
            3'b101, 3'b110: o_op = SUB1;
            default:        o_op = ZERO;
        endcase
    end
endmodule

// File: rtl/cla_adder.sv
// Parametrised adder built from a generate/propagate carry network.
module cla_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum
);
    logic [W-1:0] w_g;
    logic [W-1:0] w_p;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        logic carry;
        carry = i_cin;
        o_sum = '0;
        for (int i = 0; i < W; i++) begin
            o_sum[i] = w_p[i] ^ carry;
            carry    = w_g[i] | (w_p[i] & carry);
        end
    end
endmodule

// File: rtl/booth4_mul_param.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, full-width product.
//   state | meaning
//   IDLE  | waiting for op_start; operands latched on accept
//   EXEC  | one Booth digit per cycle, N_IT cycles; op_clear aborts
//   DONE  | result held, op_done high until op_clear
module booth4_mul_param
    import booth_pkg::*;
#(
    parameter int WA = 64,
    parameter int WB = 64
) (
    input  logic clk,
    input  logic reset,
    booth4_mul_param_if.slave bus
);
    localparam int XB   = xb_of(WB);
    localparam int N_IT = XB / 2;
    localparam int PW   = WA + WB;
    localparam int UW   = WA + 2;
    localparam int AW   = UW + XB + 1;
    localparam int CW   = $clog2(N_IT + 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_EXEC = EXEC;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]    r_state;
    logic [UW-1:0] r_a;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_result;

    booth_op_t     w_op;
    logic [UW-1:0] w_a_ext;
    logic [XB-1:0] w_b_ext;
    logic [UW-1:0] w_term;
    logic [UW-1:0] w_addend;
    logic [UW-1:0] w_sum;
    logic          w_sub;
    logic [AW-1:0] w_acc_next;

    assign w_a_ext = {{2{bus.signed_mode & bus.mtplicand[WA-1]}}, bus.mtplicand};
    assign w_b_ext = {{(XB-WB){bus.signed_mode & bus.mtplier[WB-1]}}, bus.mtplier};

    booth4_recode u_recode (
        .i_trip (r_acc[2:0]),
        .o_op   (w_op)
    );

    always_comb begin
        w_term = '0;
        w_sub  = 1'b0;
        case (w_op)
            ADD1: w_term = r_a;
            ADD2: w_term = {r_a[UW-2:0], 1'b0};
            SUB1: begin w_term = r_a;                 w_sub = 1'b1; end
            SUB2: begin w_term = {r_a[UW-2:0], 1'b0}; w_sub = 1'b1; end
            default: ;
        endcase
    end

    // Subtraction as add of the inverted term with carry-in.
    assign w_addend = w_sub ? ~w_term : w_term;

    cla_adder #(.W(UW)) u_add (
        .i_a   (r_acc[AW-1 -: UW]),
        .i_b   (w_addend),
        .i_cin (w_sub),
        .o_sum (w_sum)
    );

    assign w_acc_next = $signed({w_sum, r_acc[XB:0]}) >>> 2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.op_start && !bus.op_clear) begin
                        r_a     <= w_a_ext;
                        r_acc   <= {{UW{1'b0}}, w_b_ext, 1'b0};
                        r_cnt   <= '0;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (bus.op_clear) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(N_IT - 1)) begin
                            r_result <= w_acc_next[PW:1];
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.op_clear) begin
                        r_result <= '0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (r_state == ST_EXEC);
    assign bus.op_done = (r_state == ST_DONE);
    assign bus.result  = r_result;
endmodule
